// File: rtl/cla_bist_pkg.sv
// cla_bist_pkg: FSM state enum, default WIDTH/SETTLE and exhaustive vector count for the CLA self-test
package cla_bist_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SETTLE = 1;
  localparam int NVEC = 1 << (2 * DEF_WIDTH);
endpackage

// File: rtl/cla_bist_vec_cnt.sv
// cla_bist_vec_cnt: N-bit operand-pair counter (in: clk, rst, i_clr, i_inc; out: o_cnt, o_last at LAST)
module cla_bist_vec_cnt
  import cla_bist_pkg::*;
#(
  parameter int N = 2 * DEF_WIDTH,
  parameter int LAST = NVEC - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [N-1:0] o_cnt,
  output logic         o_last
);
  logic [N-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
  assign o_last = r_cnt == N'(LAST);
endmodule

// File: rtl/cla_bist.sv
// cla_bist: exhaustive CLA self-test (in: clk, rst, start, sum_i, cout_i; out: a_o, b_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b)
module cla_bist
  import cla_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);
  localparam int HW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  state_t             r_state, w_state_d;
  logic [HW-1:0]      r_hold;
  logic [2*WIDTH:0]   r_err;
  logic               r_fv;
  logic [WIDTH-1:0]   r_fa, r_fb;
  logic [2*WIDTH-1:0] w_vec;
  logic               w_last, w_go, w_check, w_mis;
  cla_bist_vec_cnt #(
    .N(2 * WIDTH),
    .LAST((1 << (2 * WIDTH)) - 1)
  ) u_vec (
    .clk(clk),
    .rst(rst),
    .i_clr(w_go),
    .i_inc(w_check),
    .o_cnt(w_vec),
    .o_last(w_last)
  );
  assign {a_o, b_o} = w_vec;
  assign w_go = start && r_state != HOLD;
  assign w_check = r_state == HOLD && r_hold == '0;
  assign w_mis = ({1'b0, a_o} + {1'b0, b_o}) != {cout_i, sum_i};
  always_comb w_state_d = w_go ? HOLD : (w_check && w_last) ? DONE : r_state;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_d;
  always_ff @(posedge clk)
    if (rst || w_go) begin
      r_hold <= rst ? '0 : HW'(SETTLE);
      r_err <= '0;
      r_fv <= 1'b0;
      r_fa <= '0;
      r_fb <= '0;
    end else if (r_state == HOLD) begin
      r_hold <= w_check ? HW'(SETTLE) : r_hold - 1'b1;
      if (w_check && w_mis) begin
        r_err <= r_err + 1'b1;
        if (!r_fv) begin
          r_fv <= 1'b1;
          r_fa <= a_o;
          r_fb <= b_o;
        end
      end
    end
  assign busy = r_state == HOLD;
  assign done = r_state == DONE;
  assign pass = done && r_err == '0;
  assign err_cnt = r_err;
  assign fail_valid = r_fv;
  assign fail_a = r_fa;
  assign fail_b = r_fb;
endmodule

// File: tb/tb_cla_bist.sv
// tb_cla_bist: runs cla_bist against a fault-injectable CLA model and a spec-level scoreboard
module tb_cla_bist;
  import cla_bist_pkg::*;
  logic clk = 0, rst = 1, start = 0, start2 = 0;
  always #5 clk = ~clk;
  int fault = 0, fault2 = 0;
  int checks = 0, failures = 0;
  logic mask [NVEC];
  logic [3:0] a, b, sum, fa, fb, a2, b2, sum2, fa2, fb2;
  logic cout, busy, done, pass, fv, cout2, busy2, done2, pass2, fv2;
  logic [8:0] err, err2;
  typedef struct {int fault; int err; int fv; int fa; int fb;} vec_t;
  vec_t tbl [3];
  function automatic logic [4:0] cla_f(int f, logic [3:0] x, logic [3:0] y, logic m);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (f == 1) s[0] = 1'b0;
    else if (f == 2) s[4] = 1'b1;
    else if (f == 3) s[0] = s[0] ^ m;
    return s;
  endfunction
  assign {cout, sum} = cla_f(fault, a, b, mask[{a, b}]);
  assign {cout2, sum2} = cla_f(fault2, a2, b2, mask[{a2, b2}]);
  cla_bist u_dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a), .b_o(b), .sum_i(sum), .cout_i(cout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err), .fail_valid(fv), .fail_a(fa), .fail_b(fb)
  );
  cla_bist #(.WIDTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .sum_i(sum2), .cout_i(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic model(input int f, output int e, output int v, output int xa, output int xb);
    e = 0; v = 0; xa = 0; xb = 0;
    for (int n = 0; n < NVEC; n++) begin
      int ai = n / 16, bi = n % 16;
      if (cla_f(f, 4'(ai), 4'(bi), mask[n]) != 5'(ai + bi)) begin
        e++;
        if (v == 0) begin v = 1; xa = ai; xb = bi; end
      end
    end
  endtask
  task automatic run1(input int f, input int pulse_at, input int rst_at, output int cyc);
    fault = f;
    @(negedge clk); start = 1;
    @(posedge clk); #1;
    chk("busy_at_start", busy, 1);
    chk("cleared_at_start", {done, pass, fv, err}, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      start = (cyc + 1 == pulse_at);
      rst = (cyc + 1 == rst_at);
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 3000 && cyc != rst_at);
    @(negedge clk); start = 0; rst = 0;
  endtask
  task automatic expect_done(input string nm, input int cyc, input int e, input int v, input int xa, input int xb);
    chk({nm, "_cycles"}, cyc, 512);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_err_cnt"}, err, e);
    chk({nm, "_fail_valid"}, fv, v);
    chk({nm, "_fail_a"}, fa, xa);
    chk({nm, "_fail_b"}, fb, xb);
    chk({nm, "_pass"}, pass, e == 0);
    chk({nm, "_ops_zero"}, {a, b}, 0);
  endtask
  task automatic run2(input int f, output int cyc, output int bad);
    fault2 = f;
    @(negedge clk); start2 = 1;
    @(posedge clk); #1;
    cyc = 0;
    bad = (busy2 !== 1'b1 || {a2, b2} !== 8'd0) ? 1 : 0;
    do begin
      @(negedge clk); start2 = 0;
      @(posedge clk); #1;
      cyc++;
      if (!done2 && {a2, b2} !== 8'(cyc / 4)) bad++;
    end while (!done2 && cyc < 5000);
  endtask
  initial begin
    int cyc, bad, e, v, xa, xb;
    for (int n = 0; n < NVEC; n++) mask[n] = 1'b0;
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{1, 128, 1, 0, 1};
    tbl[2] = '{2, 136, 1, 0, 0};
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ops", {a, b}, 0);
    chk("rst_flags", {busy, done, pass, fv}, 0);
    chk("rst_err_cnt", err, 0);
    chk("rst_fail_ab", {fa, fb}, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) begin
      run1(tbl[i].fault, 0, 0, cyc);
      expect_done($sformatf("table%0d", i), cyc, tbl[i].err, tbl[i].fv, tbl[i].fa, tbl[i].fb);
    end
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < NVEC; n++) mask[n] = ($urandom_range(0, 3) == 0);
      model(3, e, v, xa, xb);
      run1(3, 0, 0, cyc);
      expect_done($sformatf("random%0d", r), cyc, e, v, xa, xb);
    end
    for (int n = 0; n < NVEC; n++) mask[n] = (n == NVEC - 1);
    run1(3, 0, 0, cyc);
    expect_done("last_vec_only", cyc, 1, 1, 15, 15);
    run1(0, 100, 0, cyc);
    expect_done("start_in_hold", cyc, 0, 0, 0, 0);
    run1(2, 0, 100, cyc);
    chk("rst_mid_cycle", cyc, 100);
    chk("rst_mid_ops", {a, b}, 0);
    chk("rst_mid_flags", {busy, done, pass, fv}, 0);
    chk("rst_mid_err_cnt", err, 0);
    chk("rst_mid_fail_ab", {fa, fb}, 0);
    run1(0, 0, 0, cyc);
    expect_done("after_rst", cyc, 0, 0, 0, 0);
    run1(1, 0, 0, cyc);
    expect_done("faulty_before_restart", cyc, 128, 1, 0, 1);
    run1(0, 0, 0, cyc);
    expect_done("restart_golden", cyc, 0, 0, 0, 0);
    run2(0, cyc, bad);
    chk("settle3_cycles", cyc, 1024);
    chk("settle3_vector_timing", bad, 0);
    chk("settle3_pass", pass2, 1);
    chk("settle3_err_cnt", err2, 0);
    for (int n = 0; n < NVEC; n++) mask[n] = ($urandom_range(0, 7) == 0);
    mask[$urandom_range(0, NVEC - 1)] = 1'b1;
    model(3, e, v, xa, xb);
    run2(3, cyc, bad);
    chk("settle3_rand_cycles", cyc, 1024);
    chk("settle3_rand_err_cnt", err2, e);
    chk("settle3_rand_fail", {fv2, fa2, fb2}, {v[0], xa[3:0], xb[3:0]});
    chk("settle3_rand_pass", pass2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
